// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the fetch FSM encoding and the reset/bubble defaults.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HOLD
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Asynchronous active-low reset, load enable, updates on the falling clock edge.
module pc_reg #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else if (load) begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect handling and stall hold buffer.
// Feeds the IF/ID register; all state updates on the falling clock edge.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC  = BIT_WIDTH'(RESET_PC_DEF),
  parameter logic [BIT_WIDTH-1:0] NOP_INSTR = BIT_WIDTH'(NOP_INSTR_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 branch_taken,
  input  logic [BIT_WIDTH-1:0] branch_target,
  input  logic                 jump,
  input  logic [BIT_WIDTH-1:0] jump_target,
  input  logic [BIT_WIDTH-1:0] imem_rdata,
  input  logic                 imem_ready,
  output logic [BIT_WIDTH-1:0] imem_addr,
  output logic                 imem_req,
  output logic [BIT_WIDTH-1:0] pc_plus4_out,
  output logic [BIT_WIDTH-1:0] instr_out,
  output logic                 Write_IFID,
  output logic                 PCEn_out_FLUSH
);

  fetch_state_e         state_q, state_d;
  logic [BIT_WIDTH-1:0] hold_q, hold_d;
  logic [BIT_WIDTH-1:0] pc_q, pc_d;
  logic                 pc_load;
  logic                 redirect;
  logic [BIT_WIDTH-1:0] pc_plus4;

  pc_reg #(
    .WIDTH    (BIT_WIDTH),
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst),
    .load (pc_load),
    .pc_d (pc_d),
    .pc_q (pc_q)
  );

  assign pc_plus4     = pc_q + BIT_WIDTH'(4);
  assign imem_addr    = pc_q;
  assign pc_plus4_out = pc_plus4;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // A redirect outranks everything but reset, and is masked by a stall.
  assign redirect = (jump || branch_taken) && !stall_in && (state_q != ST_BOOT);

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    pc_d           = pc_plus4;
    pc_load        = 1'b0;
    imem_req       = 1'b0;
    instr_out      = NOP_INSTR;
    Write_IFID     = 1'b0;
    PCEn_out_FLUSH = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (!redirect && imem_ready) begin
          if (!stall_in) begin
            instr_out  = imem_rdata;
            Write_IFID = 1'b1;
            pc_load    = 1'b1;
          end else begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        instr_out = hold_q;
        if (!stall_in) begin
          Write_IFID = 1'b1;
          pc_load    = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Redirect overrides whatever the state branch produced, including dropping ready data.
    if (redirect) begin
      pc_d           = jump ? jump_target : branch_target;
      pc_load        = 1'b1;
      instr_out      = NOP_INSTR;
      Write_IFID     = 1'b1;
      PCEn_out_FLUSH = 1'b1;
      hold_d         = NOP_INSTR;
      state_d        = ST_FETCH;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Inputs change just after posedge; the DUT updates on negedge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic        Write_IFID;
  logic        PCEn_out_FLUSH;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .BIT_WIDTH(32),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .pc_plus4_out  (pc_plus4_out),
    .instr_out     (instr_out),
    .Write_IFID    (Write_IFID),
    .PCEn_out_FLUSH(PCEn_out_FLUSH)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past exactly one falling edge, landing just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] addr, input logic req,
                          input logic [31:0] instr, input logic wr, input logic fl);
    chk({tag, "_addr"},  imem_addr, addr);
    chk({tag, "_req"},   {31'd0, imem_req}, {31'd0, req});
    chk({tag, "_p4"},    pc_plus4_out, addr + 32'd4);
    chk({tag, "_instr"}, instr_out, instr);
    chk({tag, "_wr"},    {31'd0, Write_IFID}, {31'd0, wr});
    chk({tag, "_fl"},    {31'd0, PCEn_out_FLUSH}, {31'd0, fl});
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    imem_rdata = 32'h1111_1111; imem_ready = 1'b1;
    #1;
    chk_outs("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_outs("reset_held", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Release: one BOOT cycle, then sequential fetch
    rst = 1'b1; #1;
    chk_outs("boot", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 32'h0000_1000 + 32'(i); #1;
      chk_outs("seq", 32'(4 * i), 1'b1, 32'h0000_1000 + 32'(i), 1'b1, 1'b0);
      tick();
    end

    // Memory wait of three cycles at 0x10
    imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_outs("wait", 32'h10, 1'b1, 32'h0, 1'b0, 1'b0);
      tick();
    end
    imem_ready = 1'b1; imem_rdata = 32'hAAAA_0010; #1;
    chk_outs("wait_done", 32'h10, 1'b1, 32'hAAAA_0010, 1'b1, 1'b0);
    tick();

    // Stall as data arrives -> HOLD for second stall cycle
    stall_in = 1'b1; imem_rdata = 32'h8C22_0004; #1;
    chk("stall_wr", {31'd0, Write_IFID}, 32'd0);
    chk("stall_addr", imem_addr, 32'h14);
    tick();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF; #1;
    chk_outs("hold", 32'h14, 1'b0, 32'h8C22_0004, 1'b0, 1'b0);
    tick();
    stall_in = 1'b0; #1;
    chk_outs("hold_rel", 32'h14, 1'b0, 32'h8C22_0004, 1'b1, 1'b0);
    tick();
    #1;
    chk_outs("after_hold", 32'h18, 1'b1, 32'h0, 1'b0, 1'b0);

    // Jump beats branch; ready data dropped
    imem_ready = 1'b1; imem_rdata = 32'h5555_5555;
    branch_taken = 1'b1; branch_target = 32'h100;
    jump = 1'b1; jump_target = 32'h200; #1;
    chk_outs("redir_both", 32'h18, 1'b1, 32'h0, 1'b1, 1'b1);
    tick();
    jump = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0; #1;
    chk_outs("at_jump", 32'h200, 1'b1, 32'h0, 1'b0, 1'b0);
    branch_taken = 1'b1; #1;
    chk("br_flush", {31'd0, PCEn_out_FLUSH}, 32'd1);
    tick();
    branch_taken = 1'b0; #1;
    chk("at_branch", imem_addr, 32'h100);

    // Branch masked by stall, then taken when stall drops; target bits unmasked
    stall_in = 1'b1; branch_taken = 1'b1; branch_target = 32'h302; #1;
    chk_outs("br_stall", 32'h100, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    #1;
    chk("br_stall_hold", imem_addr, 32'h100);
    stall_in = 1'b0; #1;
    chk("br_rel_flush", {31'd0, PCEn_out_FLUSH}, 32'd1);
    tick();
    branch_taken = 1'b0; #1;
    chk("at_302", imem_addr, 32'h302);

    // Wrap at top of address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC; tick();
    jump = 1'b0; #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4_out, 32'h0000_0000);
    imem_ready = 1'b1; imem_rdata = 32'h0000_00AB; tick();
    #1;
    chk("wrapped", imem_addr, 32'h0);
    tick();
    #1;
    chk("at_4", imem_addr, 32'h4);

    // Reset asynchronously in the middle of HOLD
    stall_in = 1'b1; imem_rdata = 32'h0000_0077; tick();
    #1;
    chk_outs("hold2", 32'h4, 1'b0, 32'h77, 1'b0, 1'b0);
    #2;
    rst = 1'b0; #1;
    chk_outs("async_rst", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    stall_in = 1'b0; imem_ready = 1'b0; rst = 1'b1; #1;
    chk_outs("boot2", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    #1;
    chk_outs("fetch2", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
